decim_ctrl: RTL and testbench

DECIM_CTRL -- requirements
Module: decim_ctrl

---
 rtl/decim_pkg.sv | 14 +
 rtl/decim_phase_cnt.sv | 25 ++
 rtl/decim_ctrl.sv | 135 +++++++++++++
 tb/tb_decim_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared parameters and FSM state type for the decimation controller.
package decim_pkg;

  localparam int DATA_W = 62;
  localparam int DECIM  = 30;
  localparam int CNT_W  = $clog2(DECIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/decim_phase_cnt.sv
// Modulo-DECIM beat counter with synchronous clear (clear beats increment).
module decim_phase_cnt #(
  parameter int DECIM = decim_pkg::DECIM,
  localparam int CNT_W = $clog2(DECIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == CNT_W'(DECIM - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/decim_ctrl.sv
// Decimation controller: keeps one sample out of every DECIM input beats.
// Define DECIM_PHASE_EN to add a phase_sel input choosing the captured phase.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both 1.
// in_ready depends only on state (never on in_valid); out_valid, once raised,
// stays up until out_ready is seen or the controller is disabled/reset.
module decim_ctrl #(
  parameter int DATA_W = decim_pkg::DATA_W,
  parameter int DECIM  = decim_pkg::DECIM,
  localparam int CNT_W = $clog2(DECIM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
`ifdef DECIM_PHASE_EN
  input  logic [CNT_W-1:0]         phase_sel,
`endif
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [CNT_W-1:0]         phase_cnt,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output decim_pkg::state_t        dbg_state
);

  import decim_pkg::*;

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_ovf;
  logic signed [DATA_W-1:0] r_out_real;
  logic signed [DATA_W-1:0] r_out_imag;

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cap_phase;
  logic             w_beat;
  logic             w_capture;
  logic             w_hs;
  logic             w_ovf_evt;

`ifdef DECIM_PHASE_EN
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_clamped;

  assign w_phase_clamped = (phase_sel >= CNT_W'(DECIM - 1)) ? CNT_W'(DECIM - 1) : phase_sel;
  assign w_cap_phase     = r_phase;
`else
  assign w_cap_phase = '0;
`endif

  // A beat seen while enable is low is dropped: the disable flush wins.
  assign w_beat    = in_valid && r_in_ready;
  assign w_capture = w_beat && enable && (w_cnt == w_cap_phase);
  assign w_hs      = r_out_valid && out_ready;
  assign w_ovf_evt = w_capture && r_out_valid && !out_ready;

  decim_phase_cnt #(
    .DECIM (DECIM)
  ) u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (!enable),
    .i_inc (w_beat),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
`ifdef DECIM_PHASE_EN
      r_phase     <= '0;
`endif
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state    <= RUN;
            r_in_ready <= 1'b1;
`ifdef DECIM_PHASE_EN
            r_phase    <= w_phase_clamped;
`endif
          end
        end
        RUN, HOLD: begin
          if (!enable) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
          end else if (w_capture) begin
            // Newest sample wins whether or not the held one was taken.
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_out_real  <= in_real;
            r_out_imag  <= in_imag;
          end else if (w_hs) begin
            r_state     <= RUN;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_real  = r_out_real;
  assign out_imag  = r_out_imag;
  assign phase_cnt = w_cnt;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_decim_ctrl.sv
// Randomized bench for decim_ctrl against a beat-counting reference model.
module tb_decim_ctrl;

  localparam int DATA_W = 62;
  localparam int DECIM  = 30;
  localparam int CNT_W  = $clog2(DECIM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     enable;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [CNT_W-1:0]         phase_cnt;
  logic                     overflow;
  logic                     clear_ovf;
  decim_pkg::state_t        dbg_state;
`ifdef DECIM_PHASE_EN
  logic [CNT_W-1:0]         phase_sel;
`endif

  decim_ctrl #(
    .DATA_W (DATA_W),
    .DECIM  (DECIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
`ifdef DECIM_PHASE_EN
    .phase_sel (phase_sel),
`endif
    .in_valid  (in_valid),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .phase_cnt (phase_cnt),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counts input beats since enable as an unbounded integer.
  bit                       m_run;
  int                       m_beats;
  int                       m_phase;
  bit                       m_valid;
  bit                       m_ovf;
  logic signed [DATA_W-1:0] m_re;
  logic signed [DATA_W-1:0] m_im;

  task automatic model_update();
    bit cap;
    bit evt;
    evt = 1'b0;
    if (reset) begin
      m_run = 0; m_beats = 0; m_phase = 0; m_valid = 0; m_ovf = 0;
      m_re = '0; m_im = '0;
      exp_q.delete();
    end else begin
      if (!m_run) begin
        if (enable) begin
          m_run = 1;
`ifdef DECIM_PHASE_EN
          m_phase = (int'(phase_sel) >= DECIM) ? DECIM - 1 : int'(phase_sel);
`endif
        end
      end else if (!enable) begin
        m_run = 0; m_beats = 0; m_valid = 0;
        exp_q.delete();
      end else begin
        cap = in_valid && ((m_beats % DECIM) == m_phase);
        if (cap) begin
          evt = m_valid && !out_ready;
          if (evt) void'(exp_q.pop_back());
          exp_q.push_back(in_real);
          m_valid = 1; m_re = in_real; m_im = in_imag;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
        if (in_valid) m_beats++;
      end
      if (evt) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  endtask

  task automatic compare_all();
    check("in_ready",  {63'd0, in_ready},  {63'd0, m_run});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("out_real",  64'(out_real), 64'(m_re));
    check("out_imag",  64'(out_imag), 64'(m_im));
    check("phase_cnt", 64'(phase_cnt), 64'(m_beats % DECIM));
    check("overflow",  {63'd0, overflow},  {63'd0, m_ovf});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (!reset && m_valid && out_ready && exp_q.size() > 0)
      check("delivered", 64'(out_real), 64'($signed(exp_q.pop_front())));
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Directed data: I = beat index, Q = its negation.
  task automatic drive_beat(input bit v, input bit rdy);
    in_valid  = v;
    out_ready = rdy;
    in_real   = DATA_W'(m_beats);
    in_imag   = -DATA_W'(m_beats);
  endtask

  task automatic pulse_reset();
    reset = 1; enable = 0; in_valid = 0; out_ready = 0; clear_ovf = 0;
    step();
    reset = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_real"},  64'(out_real), 64'd0);
    check({tag, "_imag"},  64'(out_imag), 64'd0);
    check({tag, "_phase"}, 64'(phase_cnt), 64'd0);
    check({tag, "_ovf"},   {63'd0, overflow}, 64'd0);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    reset = 1; enable = 0; in_valid = 0; out_ready = 0; clear_ovf = 0;
    in_real = '0; in_imag = '0;
`ifdef DECIM_PHASE_EN
    phase_sel = 7;
`endif
    m_run = 0; m_beats = 0; m_phase = 0; m_valid = 0; m_ovf = 0; m_re = '0; m_im = '0;
    step();
    step();
    check_all_zero("reset");
    reset = 0;

    // Continuous input, downstream always ready.
    enable = 1;
    for (int i = 0; i < 100; i++) begin drive_beat(1, 1); step(); end

    // Downstream stalled over two captures, accepting exactly on beat 60.
    pulse_reset();
    enable = 1;
    for (int i = 0; i < 75; i++) begin drive_beat(1, m_run && m_beats == 60); step(); end
    drive_beat(0, 0); clear_ovf = 1; step();
    clear_ovf = 0; step();

    // Stall twice to raise overflow again, then clear in the same cycle as a new overflow.
    for (int i = 0; i < 70; i++) begin
      drive_beat(1, 0);
      clear_ovf = (m_beats % DECIM == 0) ? 1'b1 : 1'b0;
      step();
    end
    clear_ovf = 0;

    // Gapped input: one beat every three cycles.
    pulse_reset();
    enable = 1;
    for (int i = 0; i < 200; i++) begin drive_beat(i % 3 == 0, 1); step(); end

    // Disable at beat 15 while holding, re-enable five cycles later.
    pulse_reset();
    enable = 1;
    for (int i = 0; i < 200 && !(m_run && m_beats == 15); i++) begin drive_beat(1, 0); step(); end
    enable = 0;
    for (int i = 0; i < 5; i++) begin drive_beat(1, 0); step(); end
    check("dis_valid", {63'd0, out_valid}, 64'd0);
    check("dis_phase", 64'(phase_cnt), 64'd0);
    enable = 1;
    for (int i = 0; i < 40; i++) begin drive_beat(1, 1); step(); end

    // Reset at the same point: everything returns to zero.
    enable = 1;
    for (int i = 0; i < 200 && !(m_run && m_beats % DECIM == 15 && m_valid); i++) begin
      drive_beat(1, 0); step();
    end
    pulse_reset();
    check_all_zero("midrst");
    enable = 1;
    for (int i = 0; i < 40; i++) begin drive_beat(1, 1); step(); end

`ifdef DECIM_PHASE_EN
    // Programmable phase 7, then an out-of-range value that clamps to DECIM-1.
    pulse_reset();
    phase_sel = 7; enable = 1;
    for (int i = 0; i < 80; i++) begin drive_beat(1, 1); step(); end
    enable = 0; step();
    phase_sel = 5'd31; enable = 1;
    for (int i = 0; i < 80; i++) begin drive_beat(1, 1); step(); end
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      enable    = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 19) == 0);
      in_real   = {$urandom, $urandom};
      in_imag   = {$urandom, $urandom};
`ifdef DECIM_PHASE_EN
      phase_sel = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
